// File: rtl/skid_pkg.sv
// -----------------------------------------------------------------------------
// skid_pkg
// Shared types and constants for the operand skid buffer and its optional
// performance counter.
//   skid_state_t       : occupancy of the 2-entry buffer (EMPTY / ONE / TWO)
//   SKID_DEFAULT_WIDTH : default data width of the operand mux output
//   STALL_CNT_MAX      : saturation value of the stall-cycle counter
// -----------------------------------------------------------------------------
package skid_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_t;

    localparam int          SKID_DEFAULT_WIDTH = 32;
    localparam logic [31:0] STALL_CNT_MAX      = 32'hFFFF_FFFF;

endpackage : skid_pkg

// File: rtl/skid_perf_counter.sv
// -----------------------------------------------------------------------------
// skid_perf_counter
// Saturating 32-bit event counter with enable. Counts one per clock while
// i_en is high and sticks at STALL_CNT_MAX. Only rst_n clears it.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (count -> 0)
//   i_en     : count this cycle
//   o_count  : current count
// -----------------------------------------------------------------------------
module skid_perf_counter
    import skid_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != STALL_CNT_MAX)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule : skid_perf_counter

// File: rtl/operand_skid_buffer.sv
// -----------------------------------------------------------------------------
// operand_skid_buffer
// Registered valid/ready stage after the 32-bit 2:1 operand mux. A 2-entry
// skid buffer (main + skid) lets in_ready be decoded purely from the state
// register while still sustaining one transfer per cycle.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   flush               : synchronous flush, drops all stored words
//   in_valid / in_data  : upstream word from the operand mux
//   in_ready            : buffer can accept (state register only)
//   out_valid/out_data  : main entry towards the execute stage
//   out_ready           : downstream accepts
//   stall_cycles        : only with OPERAND_SKID_PERF_EN defined; saturating
//                         count of cycles with in_valid=1 and in_ready=0
// Build option: define OPERAND_SKID_PERF_EN to add the stall counter.
// -----------------------------------------------------------------------------
module operand_skid_buffer
    import skid_pkg::*;
#(
    parameter int WIDTH = SKID_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
`ifdef OPERAND_SKID_PERF_EN
    output logic [31:0]      stall_cycles,
`endif
    input  logic             out_ready
);

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main;      // main <= in_data
    logic w_main_from_skid; // main <= skid (drain the skid entry)
    logic w_load_skid;      // skid <= in_data

    assign in_ready   = (r_state != TWO);
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;

        unique case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ONE;
                    w_load_main = 1'b1;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_fire) begin
                    w_state_nxt      = ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase

        // Flush wins over any transfer in the same cycle.
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the two data words are ordinary registers (not a RAM), so they take
    // the async reset and out_data reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

`ifdef OPERAND_SKID_PERF_EN
    logic w_stall;
    assign w_stall = in_valid & ~in_ready;

    skid_perf_counter u_perf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_stall),
        .o_count (stall_cycles)
    );
`endif

endmodule : operand_skid_buffer

// File: tb/tb_operand_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_operand_skid_buffer
// Directed and randomized checks of operand_skid_buffer against a queue model:
// the buffer is a FIFO of at most two words, the head is presented on the
// output, inputs are taken only while fewer than two words are held, and a
// flush empties it.
// -----------------------------------------------------------------------------
module tb_operand_skid_buffer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
`ifdef OPERAND_SKID_PERF_EN
    logic [31:0]  stall_cycles;
`endif

    operand_skid_buffer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef OPERAND_SKID_PERF_EN
        .stall_cycles (stall_cycles),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: words currently held, oldest first.
    logic [W-1:0] model_q[$];
    logic [W-1:0] delivered[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Check all outputs against the model.
    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, W'(out_valid), W'(model_q.size() != 0));
        check({tag, ".in_ready"},  W'(in_ready),  W'(model_q.size() < 2));
        if (model_q.size() != 0) check({tag, ".out_data"}, out_data, model_q[0]);
    endtask

    // One clock: inputs driven just after an edge, model advanced with the
    // pre-edge values, outputs checked 1 time unit after the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                         input logic fl, input string tag);
        bit acc, dlv;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (model_q.size() < 2);
        dlv = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (dlv) delivered.push_back(model_q[0]);
        if (fl) begin
            model_q.delete();
        end else begin
            if (dlv) void'(model_q.pop_front());
            if (acc) model_q.push_back(id);
        end
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        logic [W-1:0] words [4];
        words[0] = 32'hABCDEFFA;
        words[1] = 32'h12345678;
        words[2] = 32'hABCDEF12;
        words[3] = 32'h98765432;

        // ---------------- reset state ----------------
        #2;
        check("rst.out_valid", W'(out_valid), '0);
        check("rst.out_data",  out_data, '0);
        check("rst.in_ready",  W'(in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("post_rst");

        // ---------------- pass-through ----------------
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, words[i], 1'b1, 1'b0, "pass");
            check("pass.word", out_data, words[i]);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, "pass.drain");
        check("pass.empty", W'(out_valid), '0);

        // ---------------- backpressure / skid ----------------
        cycle(1'b1, words[0], 1'b0, 1'b0, "bp.first");
        check("bp.ready1", W'(in_ready), W'(1));
        cycle(1'b1, words[1], 1'b0, 1'b0, "bp.second");
        check("bp.ready0", W'(in_ready), '0);
        check("bp.hold",   out_data, words[0]);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "bp.stall");
        check("bp.hold2",  out_data, words[0]);
        delivered.delete();
        cycle(1'b0, '0, 1'b1, 1'b0, "bp.drain1");
        check("bp.next",   out_data, words[1]);
        cycle(1'b0, '0, 1'b1, 1'b0, "bp.drain2");
        check("bp.count",  W'(delivered.size()), W'(2));
        check("bp.order0", delivered[0], words[0]);
        check("bp.order1", delivered[1], words[1]);

        // ---------------- simultaneous in/out in ONE ----------------
        cycle(1'b1, words[3], 1'b0, 1'b0, "sim.load");
        cycle(1'b1, words[2], 1'b1, 1'b0, "sim.both");
        check("sim.data",  out_data, words[2]);
        check("sim.ready", W'(in_ready), W'(1));
        cycle(1'b0, '0, 1'b1, 1'b0, "sim.drain");

        // ---------------- flush in TWO ----------------
        cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0, "fl.a");
        cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0, "fl.b");
        cycle(1'b1, 32'h3333_3333, 1'b0, 1'b1, "fl.flush");
        check("fl.valid", W'(out_valid), '0);
        check("fl.ready", W'(in_ready), W'(1));
        cycle(1'b1, 32'h4444_4444, 1'b1, 1'b0, "fl.after");
        check("fl.newdata", out_data, 32'h4444_4444);
        cycle(1'b0, '0, 1'b1, 1'b0, "fl.drain");

        // ---------------- async reset while in TWO ----------------
        cycle(1'b1, words[0], 1'b0, 1'b0, "ar.a");
        cycle(1'b1, words[1], 1'b0, 1'b0, "ar.b");
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check("ar.valid", W'(out_valid), '0);
        check("ar.data",  out_data, '0);
        check("ar.ready", W'(in_ready), W'(1));
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("ar.released");

`ifdef OPERAND_SKID_PERF_EN
        // ---------------- stall counter ----------------
        cycle(1'b1, words[0], 1'b0, 1'b0, "perf.a");
        cycle(1'b1, words[1], 1'b0, 1'b0, "perf.b");
        for (int i = 0; i < 5; i++) cycle(1'b1, words[2], 1'b0, 1'b0, "perf.stall");
        check("perf.count", stall_cycles, 32'd5);
        cycle(1'b0, '0, 1'b1, 1'b1, "perf.flush");
        check("perf.noclear", stall_cycles, 32'd5);
`endif

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), W'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0), "rand");
        end

        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_operand_skid_buffer
